// File: rtl/sfx_pkg.sv
// Shared types and helpers for the sound-effect tone mixer and its voices.
package sfx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } voice_state_e;

    localparam int unsigned AMP_STEP_DEF = 200;
    localparam int unsigned SAT_W        = 64;

    // Width of one voice contribution: output width plus headroom for the channel count and sign.
    function automatic int unsigned mix_w(input int unsigned amp_w, input int unsigned num_ch);
        return amp_w + $clog2(num_ch) + 1;
    endfunction

    // Adds two operands and clamps the result to the signed range of out_w bits.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             out_w
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sum = a + b;
        hi  = $signed((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
        lo  = -hi - SAT_W'(1);
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/sfx_voice.sv
// One retriggerable, duration-limited square-wave voice with a registered signed contribution.
// Optional per-note volume decay is built when SFX_DECAY_EN is defined.
module sfx_voice
    import sfx_pkg::*;
#(
    parameter int unsigned DIV_W    = 22,
    parameter int unsigned DUR_W    = 26,
    parameter int unsigned VOL_W    = 3,
    parameter int unsigned AMP_STEP = AMP_STEP_DEF,
    parameter int unsigned MIX_W    = 19
`ifdef SFX_DECAY_EN
    ,
    parameter int unsigned DECAY_CYCLES = 4000000
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trig_i,
    input  logic [DIV_W-1:0]        div_i,
    input  logic [DUR_W-1:0]        dur_i,
    input  logic [VOL_W-1:0]        vol_i,
    output logic signed [MIX_W-1:0] contrib_o,
    output logic                    active_o
);

`ifdef SFX_DECAY_EN
    localparam int unsigned DCNT_W = $clog2(DECAY_CYCLES + 1);
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
`endif

    voice_state_e            state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic [DUR_W-1:0]        rem_q, rem_d;
    logic [VOL_W-1:0]        vol_q, vol_d;
    logic                    phase_q, phase_d;
    logic signed [MIX_W-1:0] contrib_q, contrib_d;
    logic [MIX_W-1:0]        mag_c;
    logic                    load_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            vol_q     <= '0;
            phase_q   <= 1'b0;
            contrib_q <= '0;
`ifdef SFX_DECAY_EN
            dcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            vol_q     <= vol_d;
            phase_q   <= phase_d;
            contrib_q <= contrib_d;
`ifdef SFX_DECAY_EN
            dcnt_q    <= dcnt_d;
`endif
        end
    end

    // Next state: a trigger with non-zero duration always (re)loads; a zero-duration trigger stops.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        vol_d   = vol_q;
        phase_d = phase_q;
`ifdef SFX_DECAY_EN
        dcnt_d  = dcnt_q;
`endif
        load_c  = trig_i && (dur_i != '0);

        case (state_q)
            IDLE: begin
                if (load_c) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (trig_i && !load_c) begin
                    state_d = IDLE;
                end else if (!trig_i) begin
                    if (rem_q == DUR_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - DUR_W'(1);
                        if (cnt_q == div_q) begin
                            cnt_d   = '0;
                            phase_d = !phase_q;
                        end else begin
                            cnt_d = cnt_q + DIV_W'(1);
                        end
`ifdef SFX_DECAY_EN
                        if (dcnt_q == DCNT_W'(DECAY_CYCLES - 1)) begin
                            dcnt_d = '0;
                            if (vol_q != '0) begin
                                vol_d = vol_q - VOL_W'(1);
                            end
                        end else begin
                            dcnt_d = dcnt_q + DCNT_W'(1);
                        end
`else
                        vol_d = vol_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_c) begin
            div_d   = div_i;
            rem_d   = dur_i;
            vol_d   = vol_i;
            cnt_d   = '0;
            phase_d = 1'b0;
`ifdef SFX_DECAY_EN
            dcnt_d  = '0;
`endif
        end
    end

    // Contribution registered from next state so it lines up with the phase register.
    always_comb begin
        mag_c     = MIX_W'(vol_d) * MIX_W'(AMP_STEP);
        contrib_d = '0;
        if (state_d == PLAY && div_d > DIV_W'(1)) begin
            contrib_d = phase_d ? $signed(mag_c) : -$signed(mag_c);
        end
    end

    assign contrib_o = contrib_q;
    assign active_o  = (state_q == PLAY);

endmodule

// File: rtl/sfx_tone_mixer.sv
// Multi-channel sound-effect generator: NUM_CH square-wave voices mixed with saturation.
// Per-voice volume decay is built when SFX_DECAY_EN is defined.
module sfx_tone_mixer
    import sfx_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DIV_W    = 22,
    parameter int unsigned DUR_W    = 26,
    parameter int unsigned VOL_W    = 3,
    parameter int unsigned AMP_STEP = AMP_STEP_DEF,
    parameter int unsigned AMP_W    = 16
`ifdef SFX_DECAY_EN
    ,
    parameter int unsigned DECAY_CYCLES = 4000000
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       trig,
    input  logic [NUM_CH*DIV_W-1:0] div_in,
    input  logic [NUM_CH*DUR_W-1:0] dur_in,
    input  logic [NUM_CH*VOL_W-1:0] vol_in,
    input  logic                    mute,
    output logic signed [AMP_W-1:0] audio_out,
    output logic [NUM_CH-1:0]       ch_active,
    output logic                    busy
);

    localparam int unsigned MIX_W = mix_w(AMP_W, NUM_CH);
    localparam int unsigned ACC_W = MIX_W + $clog2(NUM_CH);

    logic signed [MIX_W-1:0] contrib [NUM_CH];
    logic signed [ACC_W-1:0] acc_c;
    logic signed [SAT_W-1:0] sat_c;
    logic signed [AMP_W-1:0] audio_q, audio_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
        sfx_voice #(
            .DIV_W    (DIV_W),
            .DUR_W    (DUR_W),
            .VOL_W    (VOL_W),
            .AMP_STEP (AMP_STEP),
            .MIX_W    (MIX_W)
`ifdef SFX_DECAY_EN
            ,
            .DECAY_CYCLES (DECAY_CYCLES)
`endif
        ) u_voice (
            .clk       (clk),
            .rst       (rst),
            .trig_i    (trig[g]),
            .div_i     (div_in[g*DIV_W +: DIV_W]),
            .dur_i     (dur_in[g*DUR_W +: DUR_W]),
            .vol_i     (vol_in[g*VOL_W +: VOL_W]),
            .contrib_o (contrib[g]),
            .active_o  (ch_active[g])
        );
    end

    // Exact wide sum first, then a single clamp, so mixed-sign voices never see early clipping.
    always_comb begin
        acc_c = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            acc_c = acc_c + ACC_W'(contrib[k]);
        end
        sat_c   = sat_add(SAT_W'(acc_c), '0, AMP_W);
        audio_d = mute ? '0 : AMP_W'(sat_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            audio_q <= '0;
        end else begin
            audio_q <= audio_d;
        end
    end

    assign audio_out = audio_q;
    assign busy      = |ch_active;

endmodule

// File: tb/tb_sfx_tone_mixer.sv
// Scoreboard bench for sfx_tone_mixer: two instances (normal and saturating amplitude step)
// checked against a time-based reference model of each note.
module tb_sfx_tone_mixer;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 22;
    localparam int DUR_W  = 26;
    localparam int VOL_W  = 3;
    localparam int AMP_W  = 16;
    localparam int STEP_A = 200;
    localparam int STEP_B = 20000;
`ifdef SFX_DECAY_EN
    localparam int DECAY  = 8;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NUM_CH-1:0]       trig = '0;
    logic [NUM_CH*DIV_W-1:0] div_in = '0;
    logic [NUM_CH*DUR_W-1:0] dur_in = '0;
    logic [NUM_CH*VOL_W-1:0] vol_in = '0;
    logic                    mute = 1'b0;
    logic signed [AMP_W-1:0] aud_a, aud_b;
    logic [NUM_CH-1:0]       act_a, act_b;
    logic                    busy_a, busy_b;

    always #5 clk = ~clk;

    sfx_tone_mixer #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DUR_W(DUR_W), .VOL_W(VOL_W),
        .AMP_STEP(STEP_A), .AMP_W(AMP_W)
`ifdef SFX_DECAY_EN
        , .DECAY_CYCLES(DECAY)
`endif
    ) u_dut (
        .clk(clk), .rst(rst), .trig(trig), .div_in(div_in), .dur_in(dur_in),
        .vol_in(vol_in), .mute(mute), .audio_out(aud_a), .ch_active(act_a), .busy(busy_a)
    );

    sfx_tone_mixer #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DUR_W(DUR_W), .VOL_W(VOL_W),
        .AMP_STEP(STEP_B), .AMP_W(AMP_W)
`ifdef SFX_DECAY_EN
        , .DECAY_CYCLES(DECAY)
`endif
    ) u_sat (
        .clk(clk), .rst(rst), .trig(trig), .div_in(div_in), .dur_in(dur_in),
        .vol_in(vol_in), .mute(mute), .audio_out(aud_b), .ch_active(act_b), .busy(busy_b)
    );

    typedef struct {
        longint            aud_a;
        longint            aud_b;
        logic [NUM_CH-1:0] act;
        logic              busy;
    } exp_t;

    exp_t   sbq[$];
    int     total = 0;
    int     bad = 0;

    // Reference model state: one record per note, activity and phase derived from elapsed time.
    int     cdiv[NUM_CH], cdur[NUM_CH], cvol[NUM_CH];
    bit     run[NUM_CH];
    longint t0[NUM_CH], mdur[NUM_CH], mdiv[NUM_CH], mvol[NUM_CH];
    longint prev_a = 0, prev_b = 0, edge_no = 0;

    task automatic chk(input string nm, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
        end
    endtask

    function automatic longint sat16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_edge(input logic r, input logic [NUM_CH-1:0] tg, input logic mt);
        exp_t   x;
        longint sa, sb, el, v, sgn;
        edge_no++;
        x.act = '0;
        if (!r) begin
            for (int k = 0; k < NUM_CH; k++) run[k] = 1'b0;
            prev_a = 0;
            prev_b = 0;
            x.aud_a = 0;
            x.aud_b = 0;
            x.busy  = 1'b0;
        end else begin
            x.aud_a = mt ? 0 : sat16(prev_a);
            x.aud_b = mt ? 0 : sat16(prev_b);
            for (int k = 0; k < NUM_CH; k++) begin
                if (tg[k]) begin
                    if (cdur[k] > 0) begin
                        run[k]  = 1'b1;
                        t0[k]   = edge_no;
                        mdur[k] = cdur[k];
                        mdiv[k] = cdiv[k];
                        mvol[k] = cvol[k];
                    end else begin
                        run[k] = 1'b0;
                    end
                end
            end
            sa = 0;
            sb = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                el = edge_no - t0[k];
                if (run[k] && el < mdur[k]) begin
                    x.act[k] = 1'b1;
                    if (mdiv[k] >= 2) begin
                        sgn = (((el / (mdiv[k] + 1)) % 2) == 1) ? 1 : -1;
                        v = mvol[k];
`ifdef SFX_DECAY_EN
                        v = v - el / DECAY;
                        if (v < 0) v = 0;
`endif
                        sa += sgn * v * STEP_A;
                        sb += sgn * v * STEP_B;
                    end
                end
            end
            prev_a = sa;
            prev_b = sb;
            x.busy = |x.act;
        end
        sbq.push_back(x);
    endtask

    task automatic tick(input logic [NUM_CH-1:0] tg, input logic mt, input logic r);
        logic fell;
        @(negedge clk);
        trig = tg;
        mute = mt;
        for (int k = 0; k < NUM_CH; k++) begin
            div_in[k*DIV_W +: DIV_W] = DIV_W'(cdiv[k]);
            dur_in[k*DUR_W +: DUR_W] = DUR_W'(cdur[k]);
            vol_in[k*VOL_W +: VOL_W] = VOL_W'(cvol[k]);
        end
        fell = rst && !r;
        rst  = r;
        if (fell) begin
            #1;
            chk("async_rst_audio_a", aud_a, 0);
            chk("async_rst_audio_b", aud_b, 0);
            chk("async_rst_active", act_a, 0);
            chk("async_rst_busy", busy_a, 0);
        end
        model_edge(r, tg, mt);
    endtask

    task automatic set_ch(input int k, input int dv, input int du, input int vo);
        cdiv[k] = dv;
        cdur[k] = du;
        cvol[k] = vo;
    endtask

    // Monitor: the design produces a sample every clock, so one expectation is consumed per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("audio_out", aud_a, e.aud_a);
                chk("audio_out_sat", aud_b, e.aud_b);
                chk("ch_active", act_a, e.act);
                chk("ch_active_sat", act_b, e.act);
                chk("busy", busy_a, e.busy);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] tg;
        for (int k = 0; k < NUM_CH; k++) begin
            set_ch(k, 0, 0, 0);
            run[k] = 1'b0;
            t0[k] = 0; mdur[k] = 0; mdiv[k] = 0; mvol[k] = 0;
        end
        repeat (3) tick('0, 1'b0, 1'b0);

        // Note interrupted by reset, then a clean 20-cycle note.
        set_ch(0, 4, 20, 5);
        tick(4'b0001, 1'b0, 1'b1);
        repeat (6) tick('0, 1'b0, 1'b1);
        repeat (2) tick('0, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 1'b1);
        repeat (24) tick('0, 1'b0, 1'b1);

        // Duration boundaries and retrigger on the expiry edge.
        set_ch(2, 5, 0, 7);
        tick(4'b0100, 1'b0, 1'b1);
        repeat (3) tick('0, 1'b0, 1'b1);
        set_ch(2, 5, 1, 7);
        tick(4'b0100, 1'b0, 1'b1);
        repeat (3) tick('0, 1'b0, 1'b1);
        set_ch(1, 3, 5, 4);
        tick(4'b0010, 1'b0, 1'b1);
        repeat (4) tick('0, 1'b0, 1'b1);
        set_ch(1, 3, 6, 4);
        tick(4'b0010, 1'b0, 1'b1);
        repeat (8) tick('0, 1'b0, 1'b1);

        // Three loud voices in phase: saturation on the large-step instance.
        for (int k = 0; k < 3; k++) set_ch(k, 6, 30, 7);
        tick(4'b0111, 1'b0, 1'b1);
        repeat (31) tick('0, 1'b0, 1'b1);

        // Silent divisor, then mute in the middle of a note.
        set_ch(0, 1, 8, 7);
        tick(4'b0001, 1'b0, 1'b1);
        repeat (9) tick('0, 1'b0, 1'b1);
        set_ch(0, 3, 30, 6);
        tick(4'b0001, 1'b0, 1'b1);
        repeat (5) tick('0, 1'b0, 1'b1);
        repeat (4) tick('0, 1'b1, 1'b1);
        repeat (22) tick('0, 1'b0, 1'b1);

        // Retrigger with a new divisor, then stop with a zero-duration trigger.
        set_ch(3, 4, 60, 2);
        tick(4'b1000, 1'b0, 1'b1);
        repeat (7) tick('0, 1'b0, 1'b1);
        set_ch(3, 10, 60, 2);
        tick(4'b1000, 1'b0, 1'b1);
        repeat (30) tick('0, 1'b0, 1'b1);
        set_ch(3, 10, 0, 2);
        tick(4'b1000, 1'b0, 1'b1);
        repeat (3) tick('0, 1'b0, 1'b1);

        // Long-period note used to observe volume decay when enabled.
        set_ch(0, 100, 40, 3);
        tick(4'b0001, 1'b0, 1'b1);
        repeat (45) tick('0, 1'b0, 1'b1);

        // Random traffic; inputs also change between triggers and must be ignored.
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cdiv[k] = int'($urandom_range(0, 12));
                cdur[k] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
                cvol[k] = int'($urandom_range(0, 7));
                tg[k]   = ($urandom_range(0, 9) == 0);
            end
            tick(tg, $urandom_range(0, 19) == 0, 1'b1);
        end

        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drain", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
